hp_bar_ctrl: RTL and testbench
==============================

Name: hp_bar_ctrl

Overview:
Sequences the HP value shown by one on-screen health bar.
- Two requesters (player-side and opponent-side battle logic) submit damage or heal requests. A round-robin arbiter serves them.
- The block computes a saturated target HP, then animates the displayed HP one pixel per STEP_FRAMES video frames toward that target.
- It drives the bar renderer's fill-length input and flags the faint condition at 0 HP.

Parameters:
MAX_HP, 120, full HP in pixels (equals bar interior width)
STEP_FRAMES, 2, frame_tick pulses per 1-pixel animation step (1..15)
BAR_OFFSET, 2, border width added to hp_disp to form blood

Ports:
clk  in  1  system/pixel clock
rst  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse per video frame
restore  in  1  one-cycle pulse: refill to MAX_HP and clear faint
req_a  in  1  requester A request, held until ack_a
heal_a  in  1  A: 1=heal, 0=damage; stable while req_a high
amt_a  in  7  A amount in pixels; stable while req_a high
ack_a  out  1  one-cycle grant/consume pulse to A
req_b, heal_b, amt_b, ack_b  as for A, requester B
blood  out  10  fill length to bar renderer = hp_disp + BAR_OFFSET
hp_disp  out  7  displayed HP
busy  out  1  high while state is ANIM
fainted  out  1  level, high in FAINT
faint_pulse  out  1  one-cycle pulse on entry to FAINT

Behaviour:
- Reset (rst=0, async):
  - hp_tgt=hp_disp=MAX_HP; blood=122.
  - ack_a, ack_b, busy, fainted and faint_pulse = 0.
  - state=IDLE; frame counter=0; RR pointer=B, so A wins the first tie.
- All outputs are registered.
- IDLE:
  - If req_a or req_b is high at edge N, grant one requester (RR on ties; pointer moves to the winner).
  - At N+1: ack of the winner =1 for exactly one cycle, and hp_tgt is updated.
  - Damage: hp_tgt = max(hp_disp - amt, 0). Heal: hp_tgt = min(hp_disp + amt, MAX_HP). Arithmetic is 8-bit internally; no wrap.
  - At N+1, state becomes ANIM if hp_tgt != hp_disp. Otherwise state stays IDLE (amt=0, or heal at full); the ack is still given.
- Handshake:
  - A requester keeps req high and operands stable until it sees ack, then drops req on the next cycle.
  - req still high one cycle after ack is a new request.
  - The loser is not acked and is served in a later IDLE.
- ANIM:
  - busy=1 and no acks. The frame counter clears on ANIM entry and increments on frame_tick.
  - On the STEP_FRAMES-th tick, hp_disp steps by 1 toward hp_tgt and the counter clears.
  - When hp_disp==hp_tgt: if 0, go to FAINT; else go to IDLE, with busy low the same cycle.
- FAINT:
  - fainted=1, with faint_pulse at the entry cycle only.
  - Requests are acked (same one-cycle timing, RR) but discarded, so requesters never hang.
  - Only restore leaves FAINT.
- restore:
  - Highest priority, in any state.
  - Next cycle: hp_tgt=hp_disp=MAX_HP, state=IDLE, counter=0, fainted=0, busy=0.
  - A request coinciding with restore is not acked that cycle.
- frame_tick outside ANIM is ignored.
- frame_tick and arbitration in the same cycle: no interaction (ANIM not yet entered).

Optional Feature:
Macro HP_BAR_LOW_EN.
- Defined: adds output port low_hp (1 bit, reset 0), registered.
  - low_hp = 1 when 0 < hp_disp <= MAX_HP/4 (30 at default), else 0.
  - The renderer uses it to select the warning colour.
- Undefined: port absent; no other change.

Test Plan:
- Reset release, idle 10 cycles -> blood=122, hp_disp=120, busy=0, acks=0, fainted=0.
- req_a damage amt=10, STEP_FRAMES=2 -> ack_a one cycle at N+1, busy=1; hp_disp=119 after 2 ticks; hp_disp=110, blood=112 after 20 ticks; busy=0 next cycle.
- req_a and req_b asserted together, both held -> ack_a first (RR). After A's animation, ack_b; requests repeated together next time -> ack_a first again.
- hp_disp=5, req_b damage amt=20 -> hp_tgt=0; after 10 ticks hp_disp=0, faint_pulse one cycle, fainted=1. req_a heal 50 -> ack_a, hp_disp stays 0.
- Same faint state, restore pulse -> next cycle hp_disp=120, blood=122, fainted=0, state IDLE.
- hp_disp=115, heal amt=20 -> hp_tgt=120 (saturated), 10 ticks to settle. Heal amt=0 -> ack, no busy. rst asserted mid-ANIM -> immediate reset values.

Source files
------------

// File: rtl/hp_bar_ctrl.sv
// hp_bar_ctrl: sequences the HP shown by one health bar.
// Two requesters submit damage/heal through a round-robin arbiter. The block
// computes a saturated target HP, then steps the displayed HP one pixel every
// STEP_FRAMES frame ticks toward that target, and flags faint at 0 HP.
// Optional feature: define HP_BAR_LOW_EN to add the registered o_low_hp output.
module hp_bar_ctrl #(
  parameter int unsigned MAX_HP      = 120,
  parameter int unsigned STEP_FRAMES = 2,
  parameter int unsigned BAR_OFFSET  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_tick,
  input  logic       i_restore,
  input  logic       i_req_a,
  input  logic       i_heal_a,
  input  logic [6:0] i_amt_a,
  output logic       o_ack_a,
  input  logic       i_req_b,
  input  logic       i_heal_b,
  input  logic [6:0] i_amt_b,
  output logic       o_ack_b,
  output logic [9:0] o_blood,
  output logic [6:0] o_hp_disp,
  output logic       o_busy,
  output logic       o_fainted,
`ifdef HP_BAR_LOW_EN
  output logic       o_low_hp,
`endif
  output logic       o_faint_pulse
);

  localparam int unsigned HP_W    = 7;
  localparam int unsigned BLOOD_W = 10;
  localparam int unsigned CNT_W   = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ANIM  = 2'd1;
  localparam logic [1:0] S_FAINT = 2'd2;

  logic [1:0]         r_state,  w_state_nxt;
  logic [HP_W-1:0]    r_hp_tgt, w_hp_tgt_nxt;
  logic [HP_W-1:0]    r_hp_disp, w_hp_disp_nxt;
  logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
  logic               r_rr_b,   w_rr_b_nxt;
  logic               r_ack_a,  w_ack_a_nxt;
  logic               r_ack_b,  w_ack_b_nxt;
  logic               r_busy,   w_busy_nxt;
  logic               r_fainted, w_fainted_nxt;
  logic               r_faint_pulse, w_faint_pulse_nxt;
  logic [BLOOD_W-1:0] r_blood,  w_blood_nxt;
  logic               r_low_hp, w_low_hp_nxt;

  logic            w_elig_a, w_elig_b, w_win_b, w_grant, w_heal;
  logic [HP_W-1:0] w_amt, w_heal_tgt, w_dmg_tgt, w_new_tgt;
  logic [7:0]      w_sum;

  // Arbitration and target computation; a requester whose ack is showing is
  // masked so its still-high request is not granted twice.
  always_comb begin
    w_elig_a   = i_req_a & ~r_ack_a;
    w_elig_b   = i_req_b & ~r_ack_b;
    w_win_b    = w_elig_b & (~w_elig_a | ~r_rr_b);
    w_grant    = w_elig_a | w_elig_b;
    w_heal     = w_win_b ? i_heal_b : i_heal_a;
    w_amt      = w_win_b ? i_amt_b : i_amt_a;
    w_sum      = 8'(r_hp_disp) + 8'(w_amt);
    w_heal_tgt = (w_sum > 8'(MAX_HP)) ? HP_W'(MAX_HP) : w_sum[HP_W-1:0];
    w_dmg_tgt  = (w_amt >= r_hp_disp) ? '0 : r_hp_disp - w_amt;
    w_new_tgt  = w_heal ? w_heal_tgt : w_dmg_tgt;
  end

  // Next-state and next-output logic; restore overrides every state.
  always_comb begin
    w_state_nxt       = r_state;
    w_hp_tgt_nxt      = r_hp_tgt;
    w_hp_disp_nxt     = r_hp_disp;
    w_cnt_nxt         = r_cnt;
    w_rr_b_nxt        = r_rr_b;
    w_ack_a_nxt       = 1'b0;
    w_ack_b_nxt       = 1'b0;
    w_faint_pulse_nxt = 1'b0;
    if (i_restore) begin
      w_state_nxt   = S_IDLE;
      w_hp_tgt_nxt  = HP_W'(MAX_HP);
      w_hp_disp_nxt = HP_W'(MAX_HP);
      w_cnt_nxt     = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            w_ack_a_nxt  = ~w_win_b;
            w_ack_b_nxt  = w_win_b;
            w_rr_b_nxt   = w_win_b;
            w_hp_tgt_nxt = w_new_tgt;
            w_cnt_nxt    = '0;
            if (w_new_tgt != r_hp_disp) w_state_nxt = S_ANIM;
          end
        end
        S_ANIM: begin
          if (r_hp_disp == r_hp_tgt) begin
            if (r_hp_disp == '0) begin
              w_state_nxt       = S_FAINT;
              w_faint_pulse_nxt = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else if (i_frame_tick) begin
            if (r_cnt == CNT_W'(STEP_FRAMES - 1)) begin
              w_cnt_nxt     = '0;
              w_hp_disp_nxt = (r_hp_tgt > r_hp_disp) ? r_hp_disp + HP_W'(1)
                                                     : r_hp_disp - HP_W'(1);
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        S_FAINT: begin
          if (w_grant) begin
            w_ack_a_nxt = ~w_win_b;
            w_ack_b_nxt = w_win_b;
            w_rr_b_nxt  = w_win_b;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    w_busy_nxt    = (w_state_nxt == S_ANIM);
    w_fainted_nxt = (w_state_nxt == S_FAINT);
    w_blood_nxt   = BLOOD_W'(w_hp_disp_nxt) + BLOOD_W'(BAR_OFFSET);
    w_low_hp_nxt  = (w_hp_disp_nxt != '0) && (w_hp_disp_nxt <= HP_W'(MAX_HP / 4));
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_hp_tgt      <= HP_W'(MAX_HP);
      r_hp_disp     <= HP_W'(MAX_HP);
      r_cnt         <= '0;
      r_rr_b        <= 1'b1;
      r_ack_a       <= 1'b0;
      r_ack_b       <= 1'b0;
      r_busy        <= 1'b0;
      r_fainted     <= 1'b0;
      r_faint_pulse <= 1'b0;
      r_blood       <= BLOOD_W'(MAX_HP) + BLOOD_W'(BAR_OFFSET);
      r_low_hp      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hp_tgt      <= w_hp_tgt_nxt;
      r_hp_disp     <= w_hp_disp_nxt;
      r_cnt         <= w_cnt_nxt;
      r_rr_b        <= w_rr_b_nxt;
      r_ack_a       <= w_ack_a_nxt;
      r_ack_b       <= w_ack_b_nxt;
      r_busy        <= w_busy_nxt;
      r_fainted     <= w_fainted_nxt;
      r_faint_pulse <= w_faint_pulse_nxt;
      r_blood       <= w_blood_nxt;
      r_low_hp      <= w_low_hp_nxt;
    end
  end

  assign o_ack_a       = r_ack_a;
  assign o_ack_b       = r_ack_b;
  assign o_blood       = r_blood;
  assign o_hp_disp     = r_hp_disp;
  assign o_busy        = r_busy;
  assign o_fainted     = r_fainted;
  assign o_faint_pulse = r_faint_pulse;
`ifdef HP_BAR_LOW_EN
  assign o_low_hp      = r_low_hp;
`else
  logic w_low_hp_unused;
  assign w_low_hp_unused = r_low_hp;
`endif

endmodule

// File: tb/tb_hp_bar_ctrl.sv
// Testbench for hp_bar_ctrl: directed scenarios then randomized requests,
// checked against a transaction-level model of the HP bar.
module tb_hp_bar_ctrl;

  localparam int MAX_HP = 120;
  localparam int STEP   = 2;
  localparam int OFF    = 2;

  logic       clk = 1'b0;
  logic       rst_n, frame_tick, restore;
  logic       req_a, heal_a, req_b, heal_b;
  logic [6:0] amt_a, amt_b;
  logic       ack_a, ack_b, busy, fainted, faint_pulse;
  logic [9:0] blood;
  logic [6:0] hp_disp;
`ifdef HP_BAR_LOW_EN
  logic       low_hp;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int m_disp, m_tgt;
  bit m_faint, m_last_b;

  always #5 clk = ~clk;

  hp_bar_ctrl dut (
    .i_clk(clk), .i_rst(rst_n), .i_frame_tick(frame_tick), .i_restore(restore),
    .i_req_a(req_a), .i_heal_a(heal_a), .i_amt_a(amt_a), .o_ack_a(ack_a),
    .i_req_b(req_b), .i_heal_b(heal_b), .i_amt_b(amt_b), .o_ack_b(ack_b),
    .o_blood(blood), .o_hp_disp(hp_disp), .o_busy(busy), .o_fainted(fainted),
`ifdef HP_BAR_LOW_EN
    .o_low_hp(low_hp),
`endif
    .o_faint_pulse(faint_pulse)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int calc_tgt(input int disp, input bit heal, input int amt);
    if (heal) return (disp + amt > MAX_HP) ? MAX_HP : disp + amt;
    return (amt > disp) ? 0 : disp - amt;
  endfunction

  task automatic check_bar(input string tag);
    chk({tag, "_hp"}, hp_disp, m_disp);
    chk({tag, "_blood"}, blood, m_disp + OFF);
    chk({tag, "_fainted"}, fainted, m_faint);
`ifdef HP_BAR_LOW_EN
    chk({tag, "_low"}, low_hp, (m_disp > 0 && m_disp <= MAX_HP / 4));
`endif
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic tick_once();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  // Requester(s) already driving; expect grant on the next edge.
  task automatic start_req(input bit who_b);
    cyc();
    chk("ack_a", ack_a, !who_b);
    chk("ack_b", ack_b, who_b);
    m_last_b = who_b;
    if (!m_faint)
      m_tgt = who_b ? calc_tgt(m_disp, heal_b, amt_b) : calc_tgt(m_disp, heal_a, amt_a);
    chk("busy_after_ack", busy, (!m_faint && m_tgt != m_disp));
    check_bar("grant");
    cyc();
    chk("ack_a_one_cycle", ack_a, 0);
    chk("ack_b_one_cycle", ack_b, 0);
    if (who_b) req_b = 1'b0; else req_a = 1'b0;
  endtask

  task automatic run_anim();
    while (m_disp != m_tgt) begin
      for (int k = 0; k < STEP; k++) begin
        repeat ($urandom_range(0, 2)) cyc();
        tick_once();
        if (k < STEP - 1) chk("hold_between_ticks", hp_disp, m_disp);
      end
      m_disp += (m_tgt > m_disp) ? 1 : -1;
      check_bar("step");
      chk("busy_anim", busy, 1);
    end
    cyc();
    if (m_disp == 0) begin
      m_faint = 1'b1;
      chk("faint_pulse_entry", faint_pulse, 1);
      chk("busy_faint", busy, 0);
      check_bar("faint");
      cyc();
      chk("faint_pulse_once", faint_pulse, 0);
      chk("fainted_level", fainted, 1);
    end else begin
      chk("busy_done", busy, 0);
      chk("faint_pulse_idle", faint_pulse, 0);
      check_bar("done");
    end
  endtask

  task automatic serve(input bit who_b);
    start_req(who_b);
    if (!m_faint && m_tgt != m_disp) run_anim();
  endtask

  task automatic set_a(input bit h, input int amt);
    heal_a = h; amt_a = 7'(amt); req_a = 1'b1;
  endtask

  task automatic set_b(input bit h, input int amt);
    heal_b = h; amt_b = 7'(amt); req_b = 1'b1;
  endtask

  task automatic do_restore(input bit with_req);
    if (with_req) set_a(1'($urandom), $urandom_range(0, 127));
    restore = 1'b1;
    cyc();
    restore = 1'b0;
    m_disp = MAX_HP; m_tgt = MAX_HP; m_faint = 1'b0;
    chk("restore_ack_a", ack_a, 0);
    chk("restore_ack_b", ack_b, 0);
    chk("restore_busy", busy, 0);
    check_bar("restore");
    if (with_req) serve(1'b0);
  endtask

  function automatic int rand_amt();
    return ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 25);
  endfunction

  initial begin
    bit wb;
    int wt, a_amt, b_amt;
    bit a_h, b_h;
    rst_n = 1'b0; frame_tick = 1'b0; restore = 1'b0;
    req_a = 1'b0; heal_a = 1'b0; amt_a = '0;
    req_b = 1'b0; heal_b = 1'b0; amt_b = '0;
    m_disp = MAX_HP; m_tgt = MAX_HP; m_faint = 1'b0; m_last_b = 1'b1;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) cyc();
    check_bar("reset");
    chk("reset_busy", busy, 0);
    chk("reset_ack_a", ack_a, 0);
    chk("reset_ack_b", ack_b, 0);
    chk("reset_faint_pulse", faint_pulse, 0);

    // Simultaneous requests: A first after reset, then B, then A again
    set_a(1'b0, 4); set_b(1'b0, 6);
    serve(1'b0); serve(1'b1);
    set_a(1'b0, 3); set_b(1'b1, 5);
    serve(1'b0); serve(1'b1);

    // Refill, then damage 10 from full
    do_restore(1'b0);
    set_a(1'b0, 10); serve(1'b0);

    // Drive to 5 HP, then faint via B; requests in faint are acked and ignored
    set_a(1'b0, m_disp - 5); serve(1'b0);
    set_b(1'b0, 20); serve(1'b1);
    set_a(1'b1, 50); serve(1'b0);
    tick_once();
    chk("faint_tick_ignored", hp_disp, 0);
    do_restore(1'b1);

    // Saturated heal and zero-amount heal
    if (m_disp != MAX_HP) do_restore(1'b0);
    set_a(1'b0, 5); serve(1'b0);
    set_a(1'b1, 20); serve(1'b0);
    set_b(1'b1, 0); serve(1'b1);

    // Restore in the middle of an animation
    set_a(1'b0, 30); start_req(1'b0);
    tick_once(); tick_once(); tick_once();
    do_restore(1'b0);

    // Asynchronous reset in the middle of an animation
    set_b(1'b0, 40); start_req(1'b1);
    tick_once(); tick_once(); tick_once();
    #3 rst_n = 1'b0;
    #1;
    m_disp = MAX_HP; m_tgt = MAX_HP; m_faint = 1'b0; m_last_b = 1'b1;
    check_bar("async_reset");
    chk("async_reset_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Randomized traffic
    for (int i = 0; i < 50; i++) begin
      if (m_faint) begin
        if ($urandom_range(0, 2) == 0) do_restore(1'($urandom));
        else if ($urandom_range(0, 1) == 0) begin set_a(1'($urandom), rand_amt()); serve(1'b0); end
        else begin set_b(1'($urandom), rand_amt()); serve(1'b1); end
      end else begin
        case ($urandom_range(0, 3))
          0: begin set_a(1'($urandom), rand_amt()); serve(1'b0); end
          1: begin set_b(1'($urandom), rand_amt()); serve(1'b1); end
          2: begin
            a_h = 1'($urandom); a_amt = rand_amt();
            b_h = 1'($urandom); b_amt = rand_amt();
            wb = !m_last_b;
            wt = wb ? calc_tgt(m_disp, b_h, b_amt) : calc_tgt(m_disp, a_h, a_amt);
            if (wt == m_disp || wt == 0) begin
              if (wb) begin set_b(b_h, b_amt); serve(1'b1); end
              else begin set_a(a_h, a_amt); serve(1'b0); end
            end else begin
              set_a(a_h, a_amt); set_b(b_h, b_amt);
              serve(wb); serve(!wb);
            end
          end
          default: begin
            tick_once();
            chk("idle_tick_hp", hp_disp, m_disp);
            chk("idle_tick_busy", busy, 0);
          end
        endcase
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
